mips_wb_stage: RTL and testbench

Write-back stage of the pipelined MIPS CPU: captures the retiring instruction from the MEM stage, selects the result source, optionally extends sub-word loads, and drives the write port of the general register file. It is the writer end of the register-file interface, and it also publishes the in-flight write for the forwarding unit. It sits between the MEM/WB boundary and the register file.

---
 rtl/mips_wb_pkg.sv | 42 ++++
 rtl/mips_load_ext.sv | 31 +++
 rtl/mips_wb_stage.sv | 107 ++++++++++
 tb/tb_mips_wb_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared types and encodings for the MIPS write-back stage.
// The optional WB_LOAD_EXT_EN macro adds the stored load_type field.
package mips_wb_pkg;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_MEM  = 2'd1,
      WB_SEL_LINK = 2'd2,
      WB_SEL_RSVD = 2'd3
   } wb_sel_e;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } ld_type_e;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic [4:0]  rd;
      wb_sel_e     wb_sel;
`ifdef WB_LOAD_EXT_EN
      ld_type_e    load_type;
`endif
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] pc;
      logic        done;
   } wb_entry_t;

   // Every field cleared except pc, which restarts at the reset vector.
   function automatic wb_entry_t wb_reset_entry(input logic [31:0] reset_pc);
      wb_entry_t e;
      e    = '0;
      e.pc = reset_pc;
      return e;
   endfunction

endpackage

// File: rtl/mips_load_ext.sv
// Combinational sub-word load extraction: selects the byte or half-word
// addressed by offset and sign- or zero-extends it according to load_type.
module mips_load_ext
   import mips_wb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  load_type,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Half-words are addressed by offset[1] only; offset[0] is ignored.
   assign byte_sel = word[{offset, 3'b000} +: 8];
   assign half_sel = offset[1] ? word[31:16] : word[15:0];

   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      data = word;
      case (load_type)
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'h0, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'h0, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mips_wb_stage.sv
// MIPS write-back stage: one entry register feeding the register-file write
// port and forwarding unit. Define WB_LOAD_EXT_EN for sub-word load extension.
module mips_wb_stage
   import mips_wb_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_regwrite,
   input  logic [4:0]  in_rd,
   input  logic [1:0]  in_wb_sel,
   input  logic [2:0]  in_load_type,
   input  logic [31:0] in_alu,
   input  logic [31:0] in_mem,
   input  logic [31:0] in_pc,
   input  logic        wb_stall,
   input  logic        wb_flush,
   output logic        regwrite,
   output logic [4:0]  regaddr,
   output logic [31:0] regdata,
   output logic [31:0] pc_and_4,
   output logic        fwd_valid,
   output logic [4:0]  fwd_addr,
   output logic [31:0] fwd_data,
   output logic [31:0] wb_count
);

   wb_entry_t   entry_q, entry_d;
   logic [31:0] wb_count_q, wb_count_d;
   logic [31:0] mem_result;
   logic [31:0] result;
   logic        pending_write;

`ifdef WB_LOAD_EXT_EN
   mips_load_ext u_load_ext (
      .word      (entry_q.mem),
      .offset    (entry_q.alu[1:0]),
      .load_type (entry_q.load_type),
      .data      (mem_result)
   );
`else
   logic unused_load_type;
   assign unused_load_type = ^in_load_type;
   assign mem_result       = entry_q.mem;
`endif

   // A write to $0 is never pending; done only masks the register-file port.
   assign pending_write = entry_q.valid & entry_q.regwrite & (entry_q.rd != 5'd0);
   assign regwrite      = pending_write & ~entry_q.done;
   assign fwd_valid     = pending_write;

   always_comb begin
      result = 32'h0;
      case (entry_q.wb_sel)
         WB_SEL_ALU:  result = entry_q.alu;
         WB_SEL_MEM:  result = mem_result;
         WB_SEL_LINK: result = entry_q.pc + 32'd8;
         default:     result = 32'h0;
      endcase
   end

   assign regaddr  = entry_q.rd;
   assign regdata  = result;
   assign fwd_addr = entry_q.rd;
   assign fwd_data = result;
   assign pc_and_4 = entry_q.pc + 32'd4;
   assign wb_count = wb_count_q;

   always_comb begin
      entry_d    = entry_q;
      wb_count_d = wb_count_q + {31'h0, regwrite};
      if (wb_flush) begin
         entry_d.valid = 1'b0;
         entry_d.done  = 1'b0;
      end else if (wb_stall) begin
         // Once written, a stalled entry stays visible to forwarding but is not rewritten.
         entry_d.done = entry_q.done | regwrite;
      end else begin
         entry_d.valid     = in_valid;
         entry_d.regwrite  = in_regwrite;
         entry_d.rd        = in_rd;
         entry_d.wb_sel    = wb_sel_e'(in_wb_sel);
`ifdef WB_LOAD_EXT_EN
         entry_d.load_type = ld_type_e'(in_load_type);
`endif
         entry_d.alu       = in_alu;
         entry_d.mem       = in_mem;
         entry_d.pc        = in_pc;
         entry_d.done      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         entry_q    <= wb_reset_entry(RESET_PC);
         wb_count_q <= 32'h0;
      end else begin
         entry_q    <= entry_d;
         wb_count_q <= wb_count_d;
      end
   end

endmodule

// File: tb/tb_mips_wb_stage.sv
// Directed self-checking bench for mips_wb_stage; expected values are hand-computed.
module tb_mips_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_regwrite;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_load_type;
   logic [31:0] in_alu;
   logic [31:0] in_mem;
   logic [31:0] in_pc;
   logic        wb_stall;
   logic        wb_flush;
   logic        regwrite;
   logic [4:0]  regaddr;
   logic [31:0] regdata;
   logic [31:0] pc_and_4;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [31:0] wb_count;

   int checks = 0;
   int errors = 0;
   int rw_high;
   int fwd_high;

   mips_wb_stage dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_regwrite  (in_regwrite),
      .in_rd        (in_rd),
      .in_wb_sel    (in_wb_sel),
      .in_load_type (in_load_type),
      .in_alu       (in_alu),
      .in_mem       (in_mem),
      .in_pc        (in_pc),
      .wb_stall     (wb_stall),
      .wb_flush     (wb_flush),
      .regwrite     (regwrite),
      .regaddr      (regaddr),
      .regdata      (regdata),
      .pc_and_4     (pc_and_4),
      .fwd_valid    (fwd_valid),
      .fwd_addr     (fwd_addr),
      .fwd_data     (fwd_data),
      .wb_count     (wb_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [2:0] lt, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc);
      in_valid     = 1'b1;
      in_regwrite  = rw;
      in_rd        = rd;
      in_wb_sel    = sel;
      in_load_type = lt;
      in_alu       = alu;
      in_mem       = mem;
      in_pc        = pc;
   endtask

   task automatic bubble();
      in_valid    = 1'b0;
      in_regwrite = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
      in_valid = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_wb_sel = '0;
      in_load_type = '0; in_alu = '0; in_mem = '0; in_pc = '0;

      // Reset state
      tick(); tick();
      check("rst_regwrite", {31'h0, regwrite}, 32'h0);
      check("rst_regaddr", {27'h0, regaddr}, 32'h0);
      check("rst_regdata", regdata, 32'h0);
      check("rst_pc_and_4", pc_and_4, 32'h0000_3004);
      check("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
      check("rst_wb_count", wb_count, 32'h0);
      reset = 1'b0;

      // ALU write
      present(1'b1, 5'd8, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0000_3000);
      tick();
      check("alu_regwrite", {31'h0, regwrite}, 32'h1);
      check("alu_regaddr", {27'h0, regaddr}, 32'd8);
      check("alu_regdata", regdata, 32'h1234_5678);
      check("alu_pc_and_4", pc_and_4, 32'h0000_3004);
      check("alu_fwd_valid", {31'h0, fwd_valid}, 32'h1);
      check("alu_fwd_addr", {27'h0, fwd_addr}, 32'd8);
      check("alu_fwd_data", fwd_data, 32'h1234_5678);
      check("alu_count_before", wb_count, 32'd0);
      bubble();
      tick();
      check("alu_count_after", wb_count, 32'd1);
      check("bubble_regwrite", {31'h0, regwrite}, 32'h0);
      check("bubble_fwd_valid", {31'h0, fwd_valid}, 32'h0);

      // $0 suppression
      present(1'b1, 5'd0, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0000_3008);
      tick();
      check("r0_regwrite", {31'h0, regwrite}, 32'h0);
      check("r0_fwd_valid", {31'h0, fwd_valid}, 32'h0);
      bubble();
      tick();
      check("r0_wb_count", wb_count, 32'd1);

      // LINK
      present(1'b1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_3010);
      tick();
      check("link_regwrite", {31'h0, regwrite}, 32'h1);
      check("link_regaddr", {27'h0, regaddr}, 32'd31);
      check("link_regdata", regdata, 32'h0000_3018);
      check("link_pc_and_4", pc_and_4, 32'h0000_3014);
      bubble();
      tick();
      check("link_wb_count", wb_count, 32'd2);

      // Stall for 3 cycles after an ALU capture; new inputs must be ignored
      rw_high = 0; fwd_high = 0;
      present(1'b1, 5'd5, 2'd0, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0000_3020);
      tick();
      rw_high += int'(regwrite); fwd_high += int'(fwd_valid);
      present(1'b1, 5'd9, 2'd0, 3'd0, 32'h1111_1111, 32'h0, 32'h0000_3024);
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         rw_high += int'(regwrite); fwd_high += int'(fwd_valid);
      end
      check("stall_regaddr", {27'h0, regaddr}, 32'd5);
      check("stall_regdata", regdata, 32'hAAAA_5555);
      check("stall_rw_cycles", rw_high, 32'd1);
      check("stall_fwd_cycles", fwd_high, 32'd4);
      wb_stall = 1'b0;
      bubble();
      tick();
      check("stall_wb_count", wb_count, 32'd3);

      // Flush and stall together in the regwrite cycle
      present(1'b1, 5'd6, 2'd0, 3'd0, 32'h0000_0066, 32'h0, 32'h0000_3030);
      tick();
      check("flush_pre_regwrite", {31'h0, regwrite}, 32'h1);
      wb_flush = 1'b1; wb_stall = 1'b1;
      bubble();
      tick();
      check("flush_regwrite", {31'h0, regwrite}, 32'h0);
      check("flush_fwd_valid", {31'h0, fwd_valid}, 32'h0);
      check("flush_wb_count", wb_count, 32'd4);
      wb_flush = 1'b0; wb_stall = 1'b0;

      // Reset asserted mid-stall
      present(1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_0077, 32'h0, 32'h0000_3040);
      tick();
      wb_stall = 1'b1;
      tick();
      check("rstall_fwd_valid", {31'h0, fwd_valid}, 32'h1);
      check("rstall_wb_count", wb_count, 32'd5);
      reset = 1'b1;
      tick();
      check("rstall_regwrite", {31'h0, regwrite}, 32'h0);
      check("rstall_fwd_after", {31'h0, fwd_valid}, 32'h0);
      check("rstall_count_clr", wb_count, 32'd0);
      check("rstall_pc_and_4", pc_and_4, 32'h0000_3004);
      reset = 1'b0; wb_stall = 1'b0;
      bubble();
      tick();
      check("post_rst_regwrite", {31'h0, regwrite}, 32'h0);
      check("post_rst_count", wb_count, 32'd0);

      // MEM loads with in_mem = 32'h80FF_7F01
      present(1'b1, 5'd10, 2'd1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_3050);
      tick();
`ifdef WB_LOAD_EXT_EN
      check("lb_off3", regdata, 32'hFFFF_FF80);
`else
      check("lb_off3", regdata, 32'h80FF_7F01);
`endif
      present(1'b1, 5'd10, 2'd1, 3'd2, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_3054);
      tick();
`ifdef WB_LOAD_EXT_EN
      check("lbu_off2", regdata, 32'h0000_00FF);
`else
      check("lbu_off2", regdata, 32'h80FF_7F01);
`endif
      present(1'b1, 5'd10, 2'd1, 3'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_3058);
      tick();
`ifdef WB_LOAD_EXT_EN
      check("lh_off2", regdata, 32'hFFFF_80FF);
`else
      check("lh_off2", regdata, 32'h80FF_7F01);
`endif
      present(1'b1, 5'd10, 2'd1, 3'd4, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_305C);
      tick();
`ifdef WB_LOAD_EXT_EN
      check("lhu_off0", regdata, 32'h0000_7F01);
`else
      check("lhu_off0", regdata, 32'h80FF_7F01);
`endif

      // Reserved result source yields zero
      present(1'b1, 5'd11, 2'd3, 3'd0, 32'h5555_AAAA, 32'h1234_0000, 32'h0000_3060);
      tick();
      check("rsvd_regdata", regdata, 32'h0);
      check("rsvd_regwrite", {31'h0, regwrite}, 32'h1);
      bubble();
      tick();
      check("final_wb_count", wb_count, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
